// File: rtl/multicycle_datapath.sv
// Multicycle RV32I-subset core: datapath plus internal sequencer sharing one
// handshaked instruction/data memory port. Parametrised data width, register
// count and reset PC. Illegal instructions park the core in a sticky halt.
module multicycle_datapath #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic            halted
);

  localparam int unsigned     RW      = $clog2(NREGS);
  localparam logic [2:0]      F3_WORD = (XLEN == 64) ? 3'b011 : 3'b010;
  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'd4};

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_BRANCH,
    S_JUMP,
    S_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] alu_q, alu_d;
  logic [XLEN-1:0] mdr_q, mdr_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic            halted_q, halted_d;
  logic            retire_c;

  // Register file and its write port
  logic [XLEN-1:0] regs_q [NREGS];
  logic            rf_we;
  logic [XLEN-1:0] rf_wdata;

  // Instruction fields
  logic [6:0] opc_f;
  logic [4:0] rd_f, rs1_f, rs2_f;
  logic [2:0] f3_f;
  logic [6:0] f7_f;

  assign opc_f = ir_q[6:0];
  assign rd_f  = ir_q[11:7];
  assign f3_f  = ir_q[14:12];
  assign rs1_f = ir_q[19:15];
  assign rs2_f = ir_q[24:20];
  assign f7_f  = ir_q[31:25];

  logic [RW-1:0] rd_i, rs1_i, rs2_i;
  assign rd_i  = rd_f[RW-1:0];
  assign rs1_i = rs1_f[RW-1:0];
  assign rs2_i = rs2_f[RW-1:0];

  // Sign-extended immediates for each format
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;
  assign imm_i = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  // Instruction classification
  logic is_r, is_addi, is_load, is_store, is_branch, is_jal;
  logic r_fn_ok;
  logic rd_bad, rs1_bad, rs2_bad;
  logic uses_rd, uses_rs1, uses_rs2;
  logic legal;

  always_comb begin
    r_fn_ok = 1'b0;
    if (f7_f == 7'b0000000) begin
      r_fn_ok = (f3_f == 3'b000) || (f3_f == 3'b100) || (f3_f == 3'b110) ||
                (f3_f == 3'b111) || (f3_f == 3'b010);
    end else if (f7_f == 7'b0100000) begin
      r_fn_ok = (f3_f == 3'b000);
    end
  end

  assign is_r      = (opc_f == OP_R) && r_fn_ok;
  assign is_addi   = (opc_f == OP_IMM) && (f3_f == 3'b000);
  assign is_load   = (opc_f == OP_LOAD) && (f3_f == F3_WORD);
  assign is_store  = (opc_f == OP_STORE) && (f3_f == F3_WORD);
  assign is_branch = (opc_f == OP_BRANCH) && ((f3_f == 3'b000) || (f3_f == 3'b001));
  assign is_jal    = (opc_f == OP_JAL);

  assign rd_bad  = 32'(rd_f)  >= NREGS;
  assign rs1_bad = 32'(rs1_f) >= NREGS;
  assign rs2_bad = 32'(rs2_f) >= NREGS;

  assign uses_rd  = is_r || is_addi || is_load || is_jal;
  assign uses_rs1 = is_r || is_addi || is_load || is_store || is_branch;
  assign uses_rs2 = is_r || is_store || is_branch;

  assign legal = (is_r || is_addi || is_load || is_store || is_branch || is_jal) &&
                 !(uses_rd && rd_bad) && !(uses_rs1 && rs1_bad) && !(uses_rs2 && rs2_bad);

  // Combinational register reads; x0 always reads zero
  logic [XLEN-1:0] rs1_val, rs2_val;
  assign rs1_val = (rs1_f == 5'd0) ? '0 : regs_q[rs1_i];
  assign rs2_val = (rs2_f == 5'd0) ? '0 : regs_q[rs2_i];

  // ALU: register-register ops for R-type, address/immediate add otherwise
  logic [XLEN-1:0] alu_op2, alu_res;
  assign alu_op2 = is_r ? b_q : (is_store ? imm_s : imm_i);

  always_comb begin
    alu_res = a_q + alu_op2;
    if (is_r) begin
      unique case (f3_f)
        3'b000:  alu_res = f7_f[5] ? (a_q - alu_op2) : (a_q + alu_op2);
        3'b111:  alu_res = a_q & alu_op2;
        3'b110:  alu_res = a_q | alu_op2;
        3'b100:  alu_res = a_q ^ alu_op2;
        3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(alu_op2))};
        default: alu_res = a_q + alu_op2;
      endcase
    end
  end

  // Sequencer next-state and datapath register updates
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    alu_d       = alu_q;
    mdr_d       = mdr_q;
    retire_c    = 1'b0;
    rf_we       = 1'b0;
    rf_wdata    = '0;

    unique case (state_q)
      S_FETCH: begin
        if (mem_req_q && mem_ack) begin
          ir_d    = mem_rdata[31:0];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d = rs1_val;
        b_d = rs2_val;
        if (!legal)         state_d = S_HALT;
        else if (is_branch) state_d = S_BRANCH;
        else if (is_jal)    state_d = S_JUMP;
        else                state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_d   = alu_res;
        state_d = (is_load || is_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (mem_req_q && mem_ack) begin
          if (is_store) begin
            pc_d     = pc_q + PC_STEP;
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end else begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_wdata = is_load ? mdr_q : alu_q;
        pc_d     = pc_q + PC_STEP;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        if ((f3_f == 3'b000) ? (a_q == b_q) : (a_q != b_q)) pc_d = pc_q + imm_b;
        else                                                pc_d = pc_q + PC_STEP;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        rf_we    = 1'b1;
        rf_wdata = pc_q + PC_STEP;
        pc_d     = pc_q + imm_j;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase

    // Bus outputs are registered from the state being entered, so the request
    // rises on the edge that enters FETCH/MEM and holds steady through waits.
    mem_req_d   = (state_d == S_FETCH) || (state_d == S_MEM);
    mem_we_d    = (state_d == S_MEM) && is_store;
    mem_addr_d  = (state_d == S_FETCH) ? pc_d :
                  (state_d == S_MEM)   ? alu_d : mem_addr_q;
    mem_wdata_d = (state_d == S_MEM) ? b_q : mem_wdata_q;
    halted_d    = halted_q || (state_d == S_HALT);
  end

  // Sequencer and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      alu_q       <= '0;
      mdr_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      alu_q       <= alu_d;
      mdr_q       <= mdr_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      halted_q    <= halted_d;
    end
  end

  // Register file write port; writes to x0 are dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (rf_we && (rd_f != 5'd0)) begin
      regs_q[rd_i] <= rf_wdata;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pc        = pc_q;
  assign retire    = retire_c;
  assign halted    = halted_q;

endmodule
